// File: rtl/arrange_pkg.sv
// arrange_pkg: shared sizes and FSM state type for the arrange frame loader.
package arrange_pkg;
  localparam int N_SLOTS = 10;
  localparam int NIB_W = 4;
  localparam int FILL_W = $clog2(N_SLOTS + 1);
  localparam int FRAME_W = N_SLOTS * NIB_W;
  typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/arrange_odd_counter.sv
// arrange_odd_counter: counts odd beats in the current frame (built only with ARRANGE_LOADER_ODD_COUNT_EN).
`ifdef ARRANGE_LOADER_ODD_COUNT_EN
module arrange_odd_counter
  import arrange_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  input  logic              hold,
  output logic [FILL_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) count <= '0;
    else if (inc && !hold) count <= count + 1'b1;
  end
endmodule
`endif

// File: rtl/arrange_frame_loader.sv
// arrange_frame_loader: assembles N_SLOTS serial nibbles into a held parallel frame.
// Optional odd_count output under macro ARRANGE_LOADER_ODD_COUNT_EN.
module arrange_frame_loader
  import arrange_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NIB_W-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_abort,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FILL_W-1:0]  fill_level
`ifdef ARRANGE_LOADER_ODD_COUNT_EN
  ,
  output logic [FILL_W-1:0]  odd_count
`endif
);
  state_t            state, state_nx;
  logic [FILL_W-1:0] fill_nx;
  logic [NIB_W-1:0]  slot [N_SLOTS];
  logic              accept, handoff;
  always_comb begin
    state_nx = state;
    fill_nx = fill_level;
    in_ready = state == FILL;
    frame_valid = state == HOLD;
    accept = in_ready && in_valid && !in_abort;
    handoff = frame_valid && frame_ready;
    if (in_ready && in_abort) fill_nx = '0;
    else if (accept) begin
      fill_nx = fill_level + 1'b1;
      state_nx = fill_level == FILL_W'(N_SLOTS - 1) ? HOLD : FILL;
    end else if (handoff) begin
      fill_nx = '0;
      state_nx = FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      fill_level <= '0;
      for (int k = 0; k < N_SLOTS; k++) slot[k] <= '0;
    end else begin
      state <= state_nx;
      fill_level <= fill_nx;
      if (accept) slot[fill_level] <= in_data;
    end
  end
  // slot A lands in the MSBs to match the arrange stage's {A,B,...,J} ordering
  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    assign frame_out[FRAME_W-1-i*NIB_W -: NIB_W] = slot[i];
  end
`ifdef ARRANGE_LOADER_ODD_COUNT_EN
  arrange_odd_counter u_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && in_data[0]),
    .clr   ((in_ready && in_abort) || handoff),
    .hold  (frame_valid),
    .count (odd_count)
  );
`endif
endmodule

// File: tb/tb_arrange_frame_loader.sv
// tb_arrange_frame_loader: table-driven, directed and random checks against a slot-array reference model.
module tb_arrange_frame_loader;
  import arrange_pkg::*;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NIB_W-1:0]   in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_abort = 1'b0;
  logic [FRAME_W-1:0] frame_out;
  logic               frame_valid;
  logic               frame_ready = 1'b0;
  logic [FILL_W-1:0]  fill_level;
`ifdef ARRANGE_LOADER_ODD_COUNT_EN
  logic [FILL_W-1:0]  odd_count;
`endif
  int nchk = 0;
  int nfail = 0;
  logic [NIB_W-1:0] m_mem [N_SLOTS];
  int m_cnt = 0;
  bit m_hold = 0;

  arrange_frame_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_abort(in_abort), .frame_out(frame_out), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .fill_level(fill_level)
`ifdef ARRANGE_LOADER_ODD_COUNT_EN
    , .odd_count(odd_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, v, a, fr;
    logic [NIB_W-1:0] d;
    bit e_rdy, e_fv;
    int e_fill;
    logic [FRAME_W-1:0] e_frame;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FRAME_W-1:0] m_frame();
    logic [FRAME_W-1:0] f = '0;
    for (int k = 0; k < N_SLOTS; k++) f = {f[FRAME_W-NIB_W-1:0], m_mem[k]};
    return f;
  endfunction

  function automatic int m_odd();
    int n = 0;
    for (int k = 0; k < m_cnt; k++) n += int'(m_mem[k][0]);
    return n;
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [NIB_W-1:0] d, input bit a, input bit fr);
    rst_n = r; in_valid = v; in_data = d; in_abort = a; frame_ready = fr;
    @(posedge clk);
    if (!r) begin
      m_cnt = 0; m_hold = 0;
      for (int k = 0; k < N_SLOTS; k++) m_mem[k] = '0;
    end else if (!m_hold) begin
      if (a) m_cnt = 0;
      else if (v) begin
        m_mem[m_cnt] = d;
        m_cnt++;
        m_hold = m_cnt == N_SLOTS;
      end
    end else if (fr) begin
      m_hold = 0; m_cnt = 0;
    end
    #1;
    check("in_ready", 64'(in_ready), 64'(!m_hold));
    check("frame_valid", 64'(frame_valid), 64'(m_hold));
    check("fill_level", 64'(fill_level), 64'(m_cnt));
    check("frame_out", 64'(frame_out), 64'(m_frame()));
`ifdef ARRANGE_LOADER_ODD_COUNT_EN
    check("odd_count", 64'(odd_count), 64'(m_odd()));
`endif
  endtask

  task automatic stream(input logic [FRAME_W-1:0] f, input bit fr);
    logic [FRAME_W-1:0] s = f;
    for (int k = 0; k < N_SLOTS; k++) begin
      cyc(1, 1, s[FRAME_W-1 -: NIB_W], 0, fr);
      s = s << NIB_W;
    end
  endtask

  initial begin
    tbl[0] = '{r:0, v:0, a:0, fr:0, d:4'h0, e_rdy:1, e_fv:0, e_fill:0, e_frame:'0};
    for (int i = 0; i < N_SLOTS; i++)
      tbl[i+1] = '{r:1, v:1, a:0, fr:0, d:NIB_W'(i + 1), e_rdy:(i != N_SLOTS - 1),
                   e_fv:(i == N_SLOTS - 1), e_fill:i + 1,
                   e_frame:40'h123456789A & ~((40'h1 << (NIB_W * (N_SLOTS - 1 - i))) - 40'h1)};
    for (int i = 11; i < 16; i++)
      tbl[i] = '{r:1, v:1, a:0, fr:0, d:4'h5, e_rdy:0, e_fv:1, e_fill:10, e_frame:40'h123456789A};
    cyc(0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].fr);
      check($sformatf("tbl%0d_rdy", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_fv", i), 64'(frame_valid), 64'(tbl[i].e_fv));
      check($sformatf("tbl%0d_fill", i), 64'(fill_level), 64'(tbl[i].e_fill));
      check($sformatf("tbl%0d_frame", i), 64'(frame_out), 64'(tbl[i].e_frame));
    end
`ifdef ARRANGE_LOADER_ODD_COUNT_EN
    check("odd_1to10", 64'(odd_count), 64'd5);
`endif
    // handoff then second frame with frame_ready held high
    cyc(1, 0, 0, 0, 1);
    check("handoff_rdy", 64'(in_ready), 64'd1);
    check("handoff_fill", 64'(fill_level), 64'd0);
    stream(40'hFEDCBA9876, 1);
    check("frame2", 64'(frame_out), 64'hFEDCBA9876);
    check("frame2_fv", 64'(frame_valid), 64'd1);
    cyc(1, 0, 0, 0, 1);
    // abort collides with a valid beat: the beat is dropped
    for (int k = 1; k <= 4; k++) cyc(1, 1, NIB_W'(k), 0, 0);
    cyc(1, 1, 4'h5, 1, 0);
    check("abort_fill", 64'(fill_level), 64'd0);
`ifdef ARRANGE_LOADER_ODD_COUNT_EN
    check("abort_odd", 64'(odd_count), 64'd0);
`endif
    stream(40'h0123456789, 0);
    check("frame3", 64'(frame_out), 64'h0123456789);
    // abort and data in HOLD are ignored
    cyc(1, 1, 4'hF, 1, 0);
    check("hold_abort_frame", 64'(frame_out), 64'h0123456789);
    check("hold_abort_fv", 64'(frame_valid), 64'd1);
    check("hold_abort_fill", 64'(fill_level), 64'd10);
    // reset mid-fill
    cyc(1, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) cyc(1, 1, 4'hE, 0, 0);
    cyc(0, 1, 4'h3, 0, 0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_fv", 64'(frame_valid), 64'd0);
    check("rst_frame", 64'(frame_out), 64'd0);
    stream(40'h2468ACE135, 0);
    check("post_rst_frame", 64'(frame_out), 64'h2468ACE135);
    check("post_rst_fv", 64'(frame_valid), 64'd1);
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 60) != 0, $urandom_range(0, 9) < 7, NIB_W'($urandom),
          $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
